// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_pkg : key codes, FSM states and encodings for the card dealer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package game_pkg;

  localparam logic [3:0] KEY_NONE = 4'h0;
  localparam logic [3:0] KEY_P1   = 4'h3;
  localparam logic [3:0] KEY_P2   = 4'h1;
  localparam logic [3:0] KEY_NEW  = 4'hF;

  localparam int COLOR_W  = 2;
  localparam int NUMBER_W = 3;
  localparam int SCORE_W  = 7;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd127;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_DELIVER = 3'd1,
    S_SCORE   = 3'd2,
    S_CHECK   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/game_sequencer_card_map.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_map : decodes an LFSR sample into card color 1..3, number 1..5  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module card_map
  import game_pkg::*;
(
  input  logic [4:0]          rnd,
  output logic [COLOR_W-1:0]  color,
  output logic [NUMBER_W-1:0] number
);

  // color = (rnd[4:3] mod 3) + 1, number = (rnd[2:0] mod 5) + 1
  always_comb begin
    case (rnd[4:3])
      2'd0:    color = 2'd1;
      2'd1:    color = 2'd2;
      2'd2:    color = 2'd3;
      default: color = 2'd1;
    endcase
    case (rnd[2:0])
      3'd0:    number = 3'd1;
      3'd1:    number = 3'd2;
      3'd2:    number = 3'd3;
      3'd3:    number = 3'd4;
      3'd4:    number = 3'd5;
      3'd5:    number = 3'd1;
      3'd6:    number = 3'd2;
      default: number = 3'd3;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_sequencer : turn-based two-player dealing FSM; optional same-   |
// | color double points under macro COLOR_BONUS_EN.        Rev 1.0       |
// +----------------------------------------------------------------------+
module game_sequencer
  import game_pkg::*;
#(
  parameter int TARGET    = 21,
  parameter int MAX_DRAWS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          keypad_in,
  input  logic [4:0]          rnd,
  output logic                card_valid,
  output logic                card_player,
  output logic [COLOR_W-1:0]  card_color,
  output logic [NUMBER_W-1:0] card_number,
  output logic                turn,
  output logic [7:0]          draw_count,
  output logic [SCORE_W-1:0]  score1,
  output logic [SCORE_W-1:0]  score2,
  output logic                game_over,
  output logic [1:0]          winner
);

  localparam logic [SCORE_W-1:0] TARGET_C    = SCORE_W'(TARGET);
  localparam logic [7:0]         MAX_DRAWS_C = 8'(MAX_DRAWS);

  state_t                state_q, state_d;
  logic [3:0]            key_prev_q;
  logic                  card_valid_q, card_valid_d;
  logic                  card_player_q, card_player_d;
  logic [COLOR_W-1:0]    card_color_q, card_color_d;
  logic [NUMBER_W-1:0]   card_number_q, card_number_d;
  logic                  turn_q, turn_d;
  logic [7:0]            draw_count_q, draw_count_d;
  logic [SCORE_W-1:0]    score1_q, score1_d, score2_q, score2_d;
  logic                  game_over_q, game_over_d;
  logic [1:0]            winner_q, winner_d;

  logic [COLOR_W-1:0]    map_color;
  logic [NUMBER_W-1:0]   map_number;
  logic                  press, draw_ok, new_game;
  logic [NUMBER_W:0]     points;
  logic [SCORE_W-1:0]    cur_score, new_score;
  logic [SCORE_W:0]      sum;

  card_map u_card_map (
    .rnd    (rnd),
    .color  (map_color),
    .number (map_number)
  );

  assign press     = (keypad_in != KEY_NONE) && (key_prev_q == KEY_NONE);
  assign draw_ok   = press && (turn_q ? (keypad_in == KEY_P2) : (keypad_in == KEY_P1));
  assign new_game  = press && (keypad_in == KEY_NEW) && (state_q == S_OVER);
  assign cur_score = card_player_q ? score2_q : score1_q;
  assign sum       = {1'b0, cur_score} + {{(SCORE_W-NUMBER_W){1'b0}}, points};
  assign new_score = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];

`ifdef COLOR_BONUS_EN
  logic [COLOR_W-1:0] last_color1_q, last_color1_d, last_color2_q, last_color2_d;
  logic [COLOR_W-1:0] last_color_cur;

  assign last_color_cur = card_player_q ? last_color2_q : last_color1_q;
  // A cleared last color (0) never equals a decoded color, so the first card gets no bonus
  assign points = (card_color_q == last_color_cur) ? {card_number_q, 1'b0}
                                                   : {1'b0, card_number_q};

  always_comb begin
    last_color1_d = last_color1_q;
    last_color2_d = last_color2_q;
    if (new_game) begin
      last_color1_d = '0;
      last_color2_d = '0;
    end else if (state_q == S_DELIVER) begin
      if (card_player_q) last_color2_d = card_color_q;
      else               last_color1_d = card_color_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_color1_q <= '0;
      last_color2_q <= '0;
    end else begin
      last_color1_q <= last_color1_d;
      last_color2_q <= last_color2_d;
    end
  end
`else
  assign points = {1'b0, card_number_q};
`endif

  always_comb begin
    state_d       = state_q;
    card_valid_d  = 1'b0;
    card_player_d = card_player_q;
    card_color_d  = card_color_q;
    card_number_d = card_number_q;
    turn_d        = turn_q;
    draw_count_d  = draw_count_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    case (state_q)
      S_WAIT: begin
        if (draw_ok) begin
          card_valid_d  = 1'b1;
          card_player_d = turn_q;
          card_color_d  = map_color;
          card_number_d = map_number;
          state_d       = S_DELIVER;
        end
      end
      // Score update is registered here so it is visible while in SCORE
      S_DELIVER: begin
        if (card_player_q) score2_d = new_score;
        else               score1_d = new_score;
        draw_count_d = draw_count_q + 8'd1;
        state_d      = S_SCORE;
      end
      S_SCORE: begin
        if ((score1_q >= TARGET_C) || (score2_q >= TARGET_C) || (draw_count_q == MAX_DRAWS_C)) begin
          game_over_d = 1'b1;
          if (score1_q > score2_q)      winner_d = WIN_P1;
          else if (score2_q > score1_q) winner_d = WIN_P2;
          else                          winner_d = WIN_TIE;
        end else begin
          turn_d = ~turn_q;
        end
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = game_over_q ? S_OVER : S_WAIT;
      end
      S_OVER: begin
        if (new_game) begin
          turn_d       = 1'b0;
          draw_count_d = 8'd0;
          score1_d     = '0;
          score2_d     = '0;
          game_over_d  = 1'b0;
          winner_d     = WIN_NONE;
          state_d      = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_WAIT;
      key_prev_q    <= KEY_NONE;
      card_valid_q  <= 1'b0;
      card_player_q <= 1'b0;
      card_color_q  <= '0;
      card_number_q <= '0;
      turn_q        <= 1'b0;
      draw_count_q  <= 8'd0;
      score1_q      <= '0;
      score2_q      <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= WIN_NONE;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= keypad_in;
      card_valid_q  <= card_valid_d;
      card_player_q <= card_player_d;
      card_color_q  <= card_color_d;
      card_number_q <= card_number_d;
      turn_q        <= turn_d;
      draw_count_q  <= draw_count_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign card_valid  = card_valid_q;
  assign card_player = card_player_q;
  assign card_color  = card_color_q;
  assign card_number = card_number_q;
  assign turn        = turn_q;
  assign draw_count  = draw_count_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_sequencer : directed and random draws against a game model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_game_sequencer;

  localparam int TARGET    = 21;
  localparam int MAX_DRAWS = 20;
`ifdef COLOR_BONUS_EN
  localparam int EXP_T4_S2    = 15;
  localparam int EXP_T4_DRAWS = 5;
  localparam int EXP_T5_SCORE = 19;
  localparam int EXP_T6_SCORE = 6;
`else
  localparam int EXP_T4_S2    = 20;
  localparam int EXP_T4_DRAWS = 9;
  localparam int EXP_T5_SCORE = 10;
  localparam int EXP_T6_SCORE = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] keypad_in = 4'h0;
  logic [4:0] rnd = 5'd0;
  logic       card_valid, card_player, turn, game_over;
  logic [1:0] card_color, winner;
  logic [2:0] card_number;
  logic [7:0] draw_count;
  logic [6:0] score1, score2;

  game_sequencer #(.TARGET(TARGET), .MAX_DRAWS(MAX_DRAWS)) dut (
    .clk         (clk),
    .rst         (rst),
    .keypad_in   (keypad_in),
    .rnd         (rnd),
    .card_valid  (card_valid),
    .card_player (card_player),
    .card_color  (card_color),
    .card_number (card_number),
    .turn        (turn),
    .draw_count  (draw_count),
    .score1      (score1),
    .score2      (score2),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: a draw accepted at an edge has a lifetime of three further edges
  int         m_score [2];
  int         m_last  [2];
  int         m_draws, m_winner, m_player, m_color, m_number, m_age;
  bit         m_turn, m_over, m_valid;
  logic [3:0] m_prev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] k, input logic [4:0] r, input logic rs);
    bit pressed;
    int pts;
    if (!rs) begin
      m_score[0] = 0; m_score[1] = 0; m_last[0] = 0; m_last[1] = 0;
      m_draws = 0; m_winner = 0; m_player = 0; m_color = 0; m_number = 0;
      m_age = 0; m_turn = 0; m_over = 0; m_valid = 0; m_prev = 4'h0;
      return;
    end
    pressed = (k != 4'h0) && (m_prev == 4'h0);
    m_prev  = k;
    m_valid = 0;
    case (m_age)
      1: begin
        pts = m_number;
`ifdef COLOR_BONUS_EN
        if (m_last[m_player] == m_color) pts = 2 * m_number;
`endif
        m_score[m_player] = (m_score[m_player] + pts > 127) ? 127 : m_score[m_player] + pts;
        m_draws = (m_draws + 1) % 256;
        m_last[m_player] = m_color;
        m_age = 2;
      end
      2: begin
        if (m_score[0] >= TARGET || m_score[1] >= TARGET || m_draws == MAX_DRAWS) begin
          m_over   = 1;
          m_winner = (m_score[0] > m_score[1]) ? 1 : (m_score[1] > m_score[0]) ? 2 : 3;
        end else begin
          m_turn = !m_turn;
        end
        m_age = 3;
      end
      3: m_age = 0;
      default: begin
        if (m_over) begin
          if (pressed && k == 4'hF) begin
            m_score[0] = 0; m_score[1] = 0; m_last[0] = 0; m_last[1] = 0;
            m_draws = 0; m_winner = 0; m_turn = 0; m_over = 0;
          end
        end else if (pressed && k == (m_turn ? 4'h1 : 4'h3)) begin
          m_valid  = 1;
          m_player = int'(m_turn);
          m_color  = (int'(r[4:3]) % 3) + 1;
          m_number = (int'(r[2:0]) % 5) + 1;
          m_age    = 1;
        end
      end
    endcase
  endtask

  task automatic compare_outputs();
    chk("card_valid",  int'(card_valid),  int'(m_valid));
    chk("card_player", int'(card_player), m_player);
    chk("card_color",  int'(card_color),  m_color);
    chk("card_number", int'(card_number), m_number);
    chk("turn",        int'(turn),        int'(m_turn));
    chk("draw_count",  int'(draw_count),  m_draws);
    chk("score1",      int'(score1),      m_score[0]);
    chk("score2",      int'(score2),      m_score[1]);
    chk("game_over",   int'(game_over),   int'(m_over));
    chk("winner",      int'(winner),      m_winner);
  endtask

  task automatic step(input logic [3:0] k, input logic [4:0] r, input logic rs);
    keypad_in = k;
    rnd       = r;
    rst       = rs;
    @(posedge clk);
    model_step(k, r, rs);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'h0, 5'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    step(4'h0, 5'd0, 1'b0);
    step(4'h0, 5'd0, 1'b0);
  endtask

  task automatic draw(input logic [4:0] r);
    step(m_turn ? 4'h1 : 4'h3, r, 1'b1);
    idle(3);
  endtask

  initial begin
    int pulses;
    int n;
    logic [3:0] k, k_prev;
    logic rs;

    do_reset();
    chk("reset_score1", int'(score1), 0);
    chk("reset_turn", int'(turn), 0);
    chk("reset_winner", int'(winner), 0);
    chk("reset_color", int'(card_color), 0);

    // First draw: rnd 11100 -> color 1, number 5
    step(4'h3, 5'b11100, 1'b1);
    chk("t1_valid", int'(card_valid), 1);
    chk("t1_color", int'(card_color), 1);
    chk("t1_number", int'(card_number), 5);
    chk("t1_player", int'(card_player), 0);
    step(4'h0, 5'd0, 1'b1);
    chk("t1_score1", int'(score1), 5);
    chk("t1_valid_low", int'(card_valid), 0);
    step(4'h0, 5'd0, 1'b1);
    chk("t1_turn", int'(turn), 1);
    idle(1);

    // Wrong player's key is ignored
    do_reset();
    step(4'h1, 5'b10101, 1'b1);
    chk("t2_valid", int'(card_valid), 0);
    idle(3);
    chk("t2_draws", int'(draw_count), 0);

    // Held key yields one draw
    pulses = 0;
    repeat (10) begin
      step(4'h3, 5'b00010, 1'b1);
      pulses += int'(card_valid);
    end
    idle(4);
    chk("t3_pulses", pulses, 1);
    chk("t3_draws", int'(draw_count), 1);

    // Race to TARGET with number 5 each draw
    do_reset();
    n = 0;
    while (!m_over && n < 40) begin draw(5'b00100); n++; end
    chk("t4_over", int'(game_over), 1);
    chk("t4_winner", int'(winner), 1);
    chk("t4_score1", int'(score1), 25);
    chk("t4_score2", int'(score2), EXP_T4_S2);
    chk("t4_draws", int'(draw_count), EXP_T4_DRAWS);
    idle(1);
    step(4'h3, 5'd0, 1'b1);
    chk("t4_ignored", int'(card_valid), 0);
    idle(1);
    step(4'hF, 5'd0, 1'b1);
    chk("t4_new_over", int'(game_over), 0);
    chk("t4_new_score1", int'(score1), 0);
    chk("t4_new_draws", int'(draw_count), 0);
    chk("t4_new_winner", int'(winner), 0);
    idle(2);

    // Draw limit with number 1 each draw
    do_reset();
    n = 0;
    while (!m_over && n < 40) begin draw(5'b00000); n++; end
    chk("t5_draws", int'(draw_count), 20);
    chk("t5_winner", int'(winner), 3);
    chk("t5_score1", int'(score1), EXP_T5_SCORE);
    chk("t5_score2", int'(score2), EXP_T5_SCORE);

    // Same color twice for P1, then reset during DELIVER
    do_reset();
    draw(5'b00001);
    chk("t6_first", int'(score1), 2);
    draw(5'b00000);
    draw(5'b00001);
    chk("t6_second", int'(score1), EXP_T6_SCORE);
    step(4'h1, 5'b00100, 1'b1);
    chk("t6_deliver", int'(card_valid), 1);
    step(4'h0, 5'd0, 1'b0);
    chk("t6_rst_score2", int'(score2), 0);
    idle(4);
    chk("t6_rst_draws", int'(draw_count), 0);

    // Random play
    do_reset();
    k_prev = 4'h0;
    repeat (3000) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: k = 4'h0;
        4, 5:       k = m_turn ? 4'h1 : 4'h3;
        6:          k = m_turn ? 4'h3 : 4'h1;
        7:          k = 4'hF;
        8:          k = 4'($urandom);
        default:    k = k_prev;
      endcase
      rs = ($urandom_range(0, 399) != 0);
      step(k, 5'($urandom), rs);
      k_prev = k;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
